// File: rtl/wave_pkg.sv
// Shared definitions for the PWM wave mixer: waveform mode encodings,
// the sine table generator and the mix scaling helper.
package wave_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQUARE = 2'd3
    } wave_mode_e;

    // pi in Q30 fixed point
    localparam longint PI_Q30 = 64'sd3373259426;

    // Returns round((2^width-1)/2 * (1 + sin(2*pi*idx/2^width))) using only
    // integer arithmetic, so the table is a pure elaboration-time constant.
    // The angle is folded into the first quadrant and sin() is evaluated by
    // a Taylor series in Q30; rounding is half-up.
    function automatic int sine_sample(input int idx, input int width);
        longint n_l;
        longint quarter_l;
        longint idx_l;
        longint quad_l;
        longint r_l;
        longint x_l;
        longint x2_l;
        longint term_l;
        longint s_l;
        longint m_l;
        longint num_l;
        n_l       = 64'sd1 <<< width;
        quarter_l = n_l >>> 2;
        idx_l     = longint'(idx) % n_l;
        quad_l    = idx_l / quarter_l;
        r_l       = idx_l % quarter_l;
        if ((quad_l % 64'sd2) == 64'sd1) begin
            r_l = quarter_l - r_l;
        end
        x_l    = (PI_Q30 * r_l) / (64'sd2 * quarter_l);
        x2_l   = (x_l * x_l) >>> 30;
        term_l = x_l;
        s_l    = x_l;
        for (int k = 1; k <= 8; k++) begin
            term_l = -((term_l * x2_l) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s_l    = s_l + term_l;
        end
        if (quad_l >= 64'sd2) begin
            s_l = -s_l;
        end
        m_l   = n_l - 64'sd1;
        num_l = m_l * ((64'sd1 <<< 30) + s_l) + (64'sd1 <<< 30);
        num_l = num_l >>> 31;
        if (num_l < 64'sd0) begin
            num_l = 64'sd0;
        end
        if (num_l > m_l) begin
            num_l = m_l;
        end
        return int'(num_l);
    endfunction

    // Right-shift that keeps the sum of n full-scale samples within full
    // scale: ceil(log2(n)), with 0 for n of 0 or 1. Covers n up to 8.
    function automatic int mix_shift(input int n);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            if ((1 << k) < n) begin
                s = k + 1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/wave_shaper.sv
// Combinational waveform generator: maps a mode and the top phase bits to
// an unsigned sample of full scale 2^PWM_W-1.
module wave_shaper
    import wave_pkg::*;
#(
    parameter int PWM_W = 6
) (
    input  wave_mode_e       mode,
    input  logic [PWM_W-1:0] p,
    output logic [PWM_W-1:0] sample
);

    localparam int N = 2 ** PWM_W;

    logic [PWM_W-1:0] sine_lut_s [N];
    logic [PWM_W-1:0] tri_s;

    for (genvar gi = 0; gi < N; gi++) begin : g_sine_lut
        localparam int SINE_VAL = sine_sample(gi, PWM_W);
        assign sine_lut_s[gi] = PWM_W'(SINE_VAL);
    end

    // Select the sample for the requested waveform
    always_comb begin
        sample = '0;
        tri_s  = {p[PWM_W-2:0], 1'b0};
        case (mode)
            MODE_SINE:   sample = sine_lut_s[p];
            MODE_SAW:    sample = p;
            // Falling half is M minus the doubled phase, i.e. its complement
            MODE_TRI:    sample = p[PWM_W-1] ? ~tri_s : tri_s;
            MODE_SQUARE: sample = p[PWM_W-1] ? '1 : '0;
            default:     sample = '0;
        endcase
    end

endmodule

// File: rtl/pwm_wave_mixer.sv
// Multi-channel waveform mixer driving a single PWM output. Each frame the
// enabled channels advance their phase, their samples are summed one per
// cycle, scaled down by the enabled-channel count, and the result becomes
// the duty of the following frame.
module pwm_wave_mixer #(
    parameter int NUM_CH  = 4,
    parameter int PWM_W   = 6,
    parameter int PHASE_W = 16
) (
    input  logic               Local_clk,
    input  logic               Local_rst_n,
    input  logic [NUM_CH-1:0]  Enable_SW,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_step,
    output logic               Pulse,
    output logic [PWM_W-1:0]   Duty_Sum,
    output logic               frame_tick
);

    import wave_pkg::*;

    localparam int                ACC_W    = PWM_W + 3;
    localparam logic [PWM_W-1:0]  CNT_LAST = '1;
    localparam logic [PWM_W-1:0]  MIX_DONE = PWM_W'(NUM_CH + 1);

    logic [PWM_W-1:0]   count_r;
    wave_mode_e         shadow_mode_r [NUM_CH];
    logic [PHASE_W-1:0] shadow_step_r [NUM_CH];
    wave_mode_e         active_mode_r [NUM_CH];
    logic [NUM_CH-1:0]  active_en_r;
    logic [PHASE_W-1:0] phase_r [NUM_CH];
    logic [ACC_W-1:0]   acc_r;
    logic [PWM_W-1:0]   mix_r;
    logic [PWM_W-1:0]   duty_r;
    logic               pulse_r;
    logic               tick_r;

    logic               frame_start_s;
    wave_mode_e         sel_mode_s;
    logic [PWM_W-1:0]   sel_p_s;
    logic               sel_en_s;
    logic [PWM_W-1:0]   sample_s;
    logic [3:0]         en_cnt_s;
    logic [1:0]         shift_s;

    assign frame_start_s = (count_r == '0);
    assign Pulse         = pulse_r;
    assign Duty_Sum      = duty_r;
    assign frame_tick    = tick_r;

    // Free-running frame counter; one wrap is one PWM frame
    always_ff @(posedge Local_clk or negedge Local_rst_n) begin
        if (!Local_rst_n) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + PWM_W'(1);
        end
    end

    // Shadow configuration; indices beyond the channel count match nothing
    always_ff @(posedge Local_clk or negedge Local_rst_n) begin
        if (!Local_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_mode_r[i] <= MODE_SINE;
                shadow_step_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_we && (cfg_ch == 3'(i))) begin
                    shadow_mode_r[i] <= wave_mode_e'(cfg_mode);
                    shadow_step_r[i] <= cfg_step;
                end
            end
        end
    end

    // Frame boundary: latch config and enables, advance or clear phases.
    // The step is consumed directly from the shadow at the moment it is
    // copied, so it never needs its own active register.
    always_ff @(posedge Local_clk or negedge Local_rst_n) begin
        if (!Local_rst_n) begin
            active_en_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                active_mode_r[i] <= MODE_SINE;
                phase_r[i]       <= '0;
            end
        end else if (frame_start_s) begin
            active_en_r <= Enable_SW;
            for (int i = 0; i < NUM_CH; i++) begin
                active_mode_r[i] <= shadow_mode_r[i];
                phase_r[i]       <= Enable_SW[i] ? (phase_r[i] + shadow_step_r[i]) : '0;
            end
        end
    end

    // Pick the channel whose mix slot is this cycle (count 1..NUM_CH)
    always_comb begin
        sel_mode_s = MODE_SINE;
        sel_p_s    = '0;
        sel_en_s   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_mode_s = (count_r == PWM_W'(i + 1)) ? active_mode_r[i] : sel_mode_s;
            sel_p_s    = (count_r == PWM_W'(i + 1)) ? phase_r[i][PHASE_W-1 -: PWM_W] : sel_p_s;
            sel_en_s   = (count_r == PWM_W'(i + 1)) ? active_en_r[i] : sel_en_s;
        end
    end

    wave_shaper #(
        .PWM_W (PWM_W)
    ) u_wave_shaper (
        .mode   (sel_mode_s),
        .p      (sel_p_s),
        .sample (sample_s)
    );

    // Scale factor from the number of channels active this frame
    always_comb begin
        en_cnt_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            en_cnt_s = en_cnt_s + 4'(active_en_r[i]);
        end
        shift_s = 2'(mix_shift(int'(en_cnt_s)));
    end

    // Sequential accumulation of one enabled channel per cycle
    always_ff @(posedge Local_clk or negedge Local_rst_n) begin
        if (!Local_rst_n) begin
            acc_r <= '0;
        end else if (frame_start_s) begin
            acc_r <= '0;
        end else if (sel_en_s) begin
            acc_r <= acc_r + ACC_W'(sample_s);
        end
    end

    // Scale the finished sum, then hold it until the frame's last cycle so
    // the duty only ever changes on a frame boundary
    always_ff @(posedge Local_clk or negedge Local_rst_n) begin
        if (!Local_rst_n) begin
            mix_r  <= '0;
            duty_r <= '0;
        end else begin
            if (count_r == MIX_DONE) begin
                mix_r <= PWM_W'(acc_r >> shift_s);
            end
            if (count_r == CNT_LAST) begin
                duty_r <= mix_r;
            end
        end
    end

    // Registered PWM comparator and frame-start marker
    always_ff @(posedge Local_clk or negedge Local_rst_n) begin
        if (!Local_rst_n) begin
            pulse_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            pulse_r <= (count_r < duty_r);
            tick_r  <= (count_r == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_pwm_wave_mixer.sv
// Self-checking bench for pwm_wave_mixer: directed vector table, hand
// sequences for reset/config/PWM-width corners, and a randomized run
// against a frame-level reference model.
module tb_pwm_wave_mixer;

    localparam int    NUM_CH  = 4;
    localparam int    PWM_W   = 6;
    localparam int    PHASE_W = 16;
    localparam int    FRAME   = 64;
    localparam real   PI      = 3.14159265358979;
    localparam int    NVEC    = 17;

    logic               Local_clk;
    logic               Local_rst_n;
    logic [NUM_CH-1:0]  Enable_SW;
    logic               cfg_we;
    logic [2:0]         cfg_ch;
    logic [1:0]         cfg_mode;
    logic [PHASE_W-1:0] cfg_step;
    logic               Pulse;
    logic [PWM_W-1:0]   Duty_Sum;
    logic               frame_tick;

    pwm_wave_mixer #(
        .NUM_CH  (NUM_CH),
        .PWM_W   (PWM_W),
        .PHASE_W (PHASE_W)
    ) dut (
        .Local_clk   (Local_clk),
        .Local_rst_n (Local_rst_n),
        .Enable_SW   (Enable_SW),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_step    (cfg_step),
        .Pulse       (Pulse),
        .Duty_Sum    (Duty_Sum),
        .frame_tick  (frame_tick)
    );

    initial Local_clk = 1'b0;
    always #5 Local_clk = ~Local_clk;

    typedef struct {
        logic [3:0]  en;
        logic [1:0]  mode;
        logic [15:0] step;
        int          frame;
        int          exp_duty;
    } vec_t;

    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_cyc;
    int m_phase  [NUM_CH];
    int m_shmode [NUM_CH];
    int m_shstep [NUM_CH];
    int m_cur;
    int m_pend;
    int m_pulse;
    int m_tick;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    function automatic int ref_sample(input int mode, input int p);
        real v;
        case (mode)
            1: return p;
            2: return (p < 32) ? 2 * p : 127 - 2 * p;
            3: return (p >= 32) ? 63 : 0;
            default: begin
                v = 31.5 * (1.0 + $sin(2.0 * PI * p / 64.0));
                return $rtoi($floor(v + 0.5));
            end
        endcase
    endfunction

    task automatic model_boundary(input logic [3:0] en);
        int acc;
        int n;
        int s;
        acc = 0;
        n   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (en[i]) begin
                m_phase[i] = (m_phase[i] + m_shstep[i]) % 65536;
                acc = acc + ref_sample(m_shmode[i], m_phase[i] / 1024);
                n++;
            end else begin
                m_phase[i] = 0;
            end
        end
        s = (n <= 1) ? 0 : $clog2(n);
        m_pend = acc >> s;
    endtask

    task automatic tick();
        int          cnt;
        logic [3:0]  en;
        logic        we;
        logic [2:0]  ch;
        logic [1:0]  md;
        logic [15:0] st;
        cnt = m_cyc % FRAME;
        en  = Enable_SW;
        we  = cfg_we;
        ch  = cfg_ch;
        md  = cfg_mode;
        st  = cfg_step;
        @(posedge Local_clk);
        m_pulse = (cnt < m_cur) ? 1 : 0;
        m_tick  = (cnt == FRAME - 1) ? 1 : 0;
        if (cnt == 0) model_boundary(en);
        if (we && (int'(ch) < NUM_CH)) begin
            m_shmode[ch] = int'(md);
            m_shstep[ch] = int'(st);
        end
        if (cnt == FRAME - 1) m_cur = m_pend;
        m_cyc++;
        #1;
    endtask

    task automatic run_to(input int frame, input int cnt);
        while (m_cyc < frame * FRAME + cnt) tick();
    endtask

    task automatic write_cfg(input logic [2:0] ch, input logic [1:0] md, input logic [15:0] st);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = md;
        cfg_step = st;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        Local_rst_n = 1'b0;
        cfg_we      = 1'b0;
        cfg_ch      = 3'd0;
        cfg_mode    = 2'd0;
        cfg_step    = 16'd0;
        Enable_SW   = 4'd0;
        repeat (2) @(posedge Local_clk);
        m_cyc   = 0;
        m_cur   = 0;
        m_pend  = 0;
        m_pulse = 0;
        m_tick  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_phase[i]  = 0;
            m_shmode[i] = 0;
            m_shstep[i] = 0;
        end
        @(negedge Local_clk);
        Local_rst_n = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int nz;
        int tk;

        // en, mode, step, frame checked (mid-frame), expected Duty_Sum
        vecs[0]  = '{4'b0001, 2'd1, 16'h0400,  2,  1};
        vecs[1]  = '{4'b0001, 2'd1, 16'h0400, 10,  9};
        vecs[2]  = '{4'b0011, 2'd3, 16'h8000,  2, 63};
        vecs[3]  = '{4'b0011, 2'd3, 16'h8000,  3,  0};
        vecs[4]  = '{4'b0111, 2'd3, 16'h8000,  2, 47};
        vecs[5]  = '{4'b0111, 2'd3, 16'h8000,  3,  0};
        vecs[6]  = '{4'b1111, 2'd3, 16'h8000,  2, 63};
        vecs[7]  = '{4'b0001, 2'd2, 16'h4000,  2, 32};
        vecs[8]  = '{4'b0001, 2'd2, 16'h4000,  3, 63};
        vecs[9]  = '{4'b0001, 2'd2, 16'h4000,  4, 31};
        vecs[10] = '{4'b0001, 2'd0, 16'h4000,  2, 63};
        vecs[11] = '{4'b0001, 2'd0, 16'h4000,  4,  0};
        vecs[12] = '{4'b0001, 2'd0, 16'h4000,  5, 32};
        vecs[13] = '{4'b0000, 2'd3, 16'h8000,  2,  0};
        vecs[14] = '{4'b0011, 2'd1, 16'h0400,  3,  2};
        vecs[15] = '{4'b0111, 2'd1, 16'h0400,  5,  3};
        vecs[16] = '{4'b0001, 2'd0, 16'h2000,  2, 54};

        // reset state and three idle frames
        do_reset();
        check("rst_duty", int'(Duty_Sum), 0);
        check("rst_pulse", int'(Pulse), 0);
        check("rst_tick", int'(frame_tick), 0);
        hi = 0; nz = 0; tk = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            hi += int'(Pulse);
            nz += (Duty_Sum != '0) ? 1 : 0;
            tk += int'(frame_tick);
        end
        check("idle_pulse_high_cycles", hi, 0);
        check("idle_duty_nonzero_cycles", nz, 0);
        check("idle_frame_ticks", tk, 3);

        // directed vector table
        for (int r = 0; r < NVEC; r++) begin
            do_reset();
            run_to(0, 32);
            for (int c = 0; c < NUM_CH; c++) write_cfg(3'(c), vecs[r].mode, vecs[r].step);
            Enable_SW = vecs[r].en;
            run_to(vecs[r].frame, 32);
            check($sformatf("vec%0d_duty", r), int'(Duty_Sum), vecs[r].exp_duty);
        end

        // out-of-range channel writes ignored; mid-frame mode change deferred
        do_reset();
        run_to(0, 32);
        write_cfg(3'd0, 2'd1, 16'h2000);
        Enable_SW = 4'b0001;
        run_to(2, 30);
        write_cfg(3'd4, 2'd3, 16'h8000);
        write_cfg(3'd5, 2'd3, 16'h8000);
        run_to(3, 20);
        check("cfg_frame3_duty", int'(Duty_Sum), 16);
        run_to(3, 30);
        write_cfg(3'd0, 2'd3, 16'h2000);
        run_to(4, 32);
        check("cfg_frame4_old_mode", int'(Duty_Sum), 24);
        run_to(5, 32);
        check("cfg_frame5_new_mode", int'(Duty_Sum), 63);

        // PWM width at duty 40, then asynchronous reset mid-frame
        do_reset();
        run_to(0, 32);
        write_cfg(3'd0, 2'd1, 16'h0400);
        Enable_SW = 4'b0001;
        run_to(41, 0);
        check("pwm40_duty", int'(Duty_Sum), 40);
        hi = 0; tk = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            hi += int'(Pulse);
            tk += int'(frame_tick);
        end
        check("pwm40_high_cycles", hi, 40);
        check("pwm40_frame_ticks", tk, 1);
        run_to(42, 20);
        check("pre_async_pulse", int'(Pulse), 1);
        check("pre_async_duty", int'(Duty_Sum), 41);
        #2;
        Local_rst_n = 1'b0;
        #1;
        check("async_rst_pulse", int'(Pulse), 0);
        check("async_rst_duty", int'(Duty_Sum), 0);
        check("async_rst_tick", int'(frame_tick), 0);

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 40 * FRAME; c++) begin
            cfg_we = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = 3'($urandom_range(0, 7));
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_step = 16'($urandom);
            end
            if ($urandom_range(0, 63) == 0) Enable_SW = 4'($urandom);
            tick();
            check("rand_pulse", int'(Pulse), m_pulse);
            check("rand_tick", int'(frame_tick), m_tick);
            check("rand_duty", int'(Duty_Sum), m_cur);
        end
        cfg_we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
